ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter XLEN, default 32, width of PC, address and instruction.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_valid  input  1  downstream request to change the fetch PC.
REQ-006 redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored and treated as 0.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_addr  output  XLEN  request address, equal to the current PC.
REQ-009 imem_req_ready  input  1  memory accepts the request.
REQ-010 imem_resp_valid  input  1  response data valid, exactly one response per accepted request.
REQ-011 imem_resp_data  input  XLEN  fetched instruction word.
REQ-012 out_valid  output  1  fetched pair is valid to the decode stage.
REQ-013 out_pc  output  XLEN  PC of the presented instruction.
REQ-014 out_inst  output  XLEN  presented instruction word.
REQ-015 out_ready  input  1  decode stage accepts the pair.
REQ-016 fetch_cnt  output  XLEN  count of completed output handshakes.

Function
REQ-017 FSM has three states: S_REQ (issue), S_WAIT (await response) and S_OUT (present).
REQ-018 S_REQ: imem_req_valid = !redirect_valid; a request is accepted when imem_req_valid & imem_req_ready, then next state is S_WAIT.
REQ-019 S_WAIT: on imem_resp_valid, capture imem_resp_data into the inst register; next state is S_OUT if kill=0, else S_REQ with kill cleared.
REQ-020 S_OUT: out_valid = !redirect_valid; on out_valid & out_ready, PC <= PC+4, fetch_cnt <= fetch_cnt+1, next state S_REQ.
REQ-021 out_pc/out_inst hold stable while out_valid=1 and out_ready=0.
REQ-022 Fetch latency: minimum 3 cycles from entering S_REQ to out_valid with zero-wait memory (req accepted, resp next cycle, out the cycle after).
REQ-023 Redirect has priority over every handshake: in any state, redirect_valid=1 sets PC <= {redirect_pc[XLEN-1:2],2'b00}.
REQ-024 Redirect in S_REQ: no request is issued that cycle; state stays S_REQ.
REQ-025 Redirect in S_OUT: no output handshake, fetch_cnt unchanged, next state S_REQ.
REQ-026 Redirect in S_WAIT: kill <= 1; the in-flight response is consumed and discarded; the state stays S_WAIT until it arrives.
REQ-027 Redirect in S_WAIT in the same cycle as imem_resp_valid: the response is discarded and next state is S_REQ.
REQ-028 A repeated redirect while kill=1 updates PC only; only one response is discarded.
REQ-029 PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0); fetch_cnt wraps likewise.
REQ-030 imem_resp_valid outside S_WAIT is ignored.

Reset
REQ-031 rst=1 at a clock edge: PC <= RESET_PC, state <= S_REQ, kill <= 0, fetch_cnt <= 0, inst <= 0; rst has priority over redirect.
REQ-032 During and in the cycle after reset, out_valid=0, imem_req_valid=1 only from the first cycle with rst=0.
REQ-033 Reset mid-transaction abandons the outstanding request; memory is reset with this block.

Verification
REQ-034 Zero-wait memory, out_ready=1, resp=32'h0000_0013: out_pc sequence 8000_0000, 8000_0004, 8000_0008, each 3 cycles apart, fetch_cnt=3.
REQ-035 out_ready=0 for 5 cycles in S_OUT -> out_valid stays 1, out_pc/out_inst constant, no new imem request.
REQ-036 Redirect to 32'h8000_0103 during S_WAIT -> the pending response is dropped, the next request address is 8000_0100, and fetch_cnt is unchanged.
REQ-037 Redirect coincident with out_ready=1 in S_OUT -> no handshake counted, the next request address is redirect_pc.
REQ-038 PC=32'hFFFF_FFFC, handshake -> the next request address is 0.
REQ-039 Assert rst while in S_WAIT -> the next cycle has the FSM in S_REQ with imem_req_addr=8000_0000 and fetch_cnt=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one instruction-memory request at a time and
// presents each fetched word with its PC to decode. Redirects override every handshake.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    input  logic            out_ready,
    output logic [XLEN-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            kill_q, kill_d;

    logic            req_fire;
    logic            out_fire;
    logic            unused_redirect_lsb;

    // The low address bits of a redirect target are always forced to zero.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Handshake strobes are suppressed while reset is held so nothing leaks out of a reset cycle.
    assign imem_req_valid = (state_q == S_REQ) && !redirect_valid && !rst;
    assign out_valid      = (state_q == S_OUT) && !redirect_valid && !rst;
    assign imem_req_addr  = pc_q;
    assign out_pc         = pc_q;
    assign out_inst       = inst_q;
    assign fetch_cnt      = cnt_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    // A killed or concurrently redirected response is dropped on the floor.
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = imem_resp_data;
                        state_d = S_OUT;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (out_fire) begin
                    pc_d    = pc_q + XLEN'(4);
                    cnt_d   = cnt_q + XLEN'(1);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized run scored
// against a transaction-level model of the fetch stream and a behavioural memory.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [31:0] fetch_cnt;

    ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int n_hs  = 0;

    // Memory and stimulus knobs
    int lat_mode   = 0;    // <0: random 0..3 extra cycles, else fixed
    bit const_data = 1'b0;
    bit spur_en    = 1'b0;

    // Behavioural memory: one outstanding request, answered after its latency
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr;
    int          mem_lat;

    // Fetch-stream model: next PC to be fetched/presented and handshakes so far
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    // Previous-cycle observations and per-cycle samples for directed tests
    bit          p_ov = 1'b0, p_or = 1'b0, p_rst = 1'b1, after_rst = 1'b0;
    logic [31:0] p_pc, p_inst;
    bit          s_ov, s_rv;
    logic [31:0] s_pc, s_inst, s_ra, s_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const_data) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic scoreboard();
        bit hs;
        s_ov   = (out_valid === 1'b1);
        s_rv   = (imem_req_valid === 1'b1);
        s_pc   = out_pc;
        s_inst = out_inst;
        s_ra   = imem_req_addr;
        s_cnt  = fetch_cnt;

        if (rst || after_rst) begin
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL sb_reset_out_valid got=%b exp=0", out_valid);
            end
        end
        if (rst) begin
            n_chk++;
            if (imem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL sb_reset_req_valid got=%b exp=0", imem_req_valid);
            end
        end
        if (redirect_valid && !rst) begin
            n_chk++;
            if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL sb_redirect_blocks req=%b out=%b exp=0/0", imem_req_valid, out_valid);
            end
        end
        if (m_known && !rst) begin
            n_chk++;
            if (fetch_cnt !== m_cnt) begin
                n_err++; $display("FAIL sb_fetch_cnt got=%h exp=%h", fetch_cnt, m_cnt);
            end
            if (s_rv) begin
                n_chk++;
                if (imem_req_addr !== m_pc || mem_pend) begin
                    n_err++; $display("FAIL sb_req got addr=%h pend=%b exp addr=%h pend=0", imem_req_addr, mem_pend, m_pc);
                end
            end
            if (s_ov) begin
                n_chk++;
                if (out_pc !== m_pc || out_inst !== mem_word(m_pc)) begin
                    n_err++; $display("FAIL sb_out got pc=%h inst=%h exp pc=%h inst=%h", out_pc, out_inst, m_pc, mem_word(m_pc));
                end
            end
            if (p_ov && !p_or && !p_rst && s_ov) begin
                n_chk++;
                if (out_pc !== p_pc || out_inst !== p_inst) begin
                    n_err++; $display("FAIL sb_hold got pc=%h inst=%h exp pc=%h inst=%h", out_pc, out_inst, p_pc, p_inst);
                end
            end
        end

        // Predict the effect of the coming edge
        hs = !rst && s_ov && (out_ready === 1'b1);
        if (rst) begin
            m_known = 1'b1;
            m_pc    = RESET_PC;
            m_cnt   = '0;
        end else if (redirect_valid) begin
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (hs) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
            n_hs++;
        end

        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (mem_pend) begin
                if (imem_resp_valid) mem_pend = 1'b0;
                else if (mem_lat > 0) mem_lat--;
            end
            if (s_rv && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_addr = imem_req_addr;
                mem_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
        end

        p_ov      = s_ov && !rst;
        p_or      = out_ready;
        p_pc      = out_pc;
        p_inst    = out_inst;
        p_rst     = rst;
        after_rst = rst;
    endtask

    // One clock cycle: memory drives its response, outputs are scored at the falling edge.
    task automatic cycle();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (mem_pend && mem_lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
        end else if (!mem_pend && spur_en && $urandom_range(0, 3) == 0) begin
            imem_resp_valid = 1'b1;
        end
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_out(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_ov) begin ok = 1'b1; break; end
        end
        n_chk++;
        if (!ok) begin n_err++; $display("FAIL %s out_valid_timeout got=0 exp=1", name); end
    endtask

    task automatic wait_req(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_rv) begin ok = 1'b1; break; end
            n_chk++;
            if (s_ov) begin n_err++; $display("FAIL %s dropped_resp_presented got out_pc=%h exp none", name, s_pc); end
        end
        n_chk++;
        if (!ok) begin n_err++; $display("FAIL %s req_timeout got=0 exp=1", name); end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1234;
        imem_req_ready = 1'b1; out_ready = 1'b1;
        cycle(); cycle();
        n_chk++;
        if (s_ov || s_rv) begin n_err++; $display("FAIL reset_outputs got ov=%b rv=%b exp 0/0", s_ov, s_rv); end
        rst = 1'b0; redirect_valid = 1'b0;
        cycle();
        n_chk++;
        if (!s_rv || s_ra !== RESET_PC || s_cnt !== 32'd0 || s_ov) begin
            n_err++; $display("FAIL reset_first_req got rv=%b addr=%h cnt=%h ov=%b exp 1/%h/0/0", s_rv, s_ra, s_cnt, s_ov, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        int          hs_cyc[$];
        logic [31:0] hs_pc[$];
        const_data = 1'b1; lat_mode = 0; imem_req_ready = 1'b1; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (s_ov) begin hs_cyc.push_back(c); hs_pc.push_back(s_pc); end
        end
        n_chk++;
        if (hs_cyc.size() != 3) begin
            n_err++; $display("FAIL zero_wait_count got=%0d exp=3", hs_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (hs_cyc[k] != 2 + 3 * k || hs_pc[k] !== RESET_PC + 32'(4 * k)) begin
                    n_err++; $display("FAIL zero_wait_seq%0d got cyc=%0d pc=%h exp cyc=%0d pc=%h", k, hs_cyc[k], hs_pc[k], 2 + 3 * k, RESET_PC + 32'(4 * k));
                end
            end
        end
        n_chk++;
        if (s_cnt !== 32'd3) begin n_err++; $display("FAIL zero_wait_cnt got=%h exp=3", s_cnt); end
        const_data = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] pc0, inst0;
        lat_mode = 1; out_ready = 1'b0;
        do_reset();
        wait_out("stall");
        pc0 = s_pc; inst0 = s_inst;
        n_chk++;
        if (pc0 !== RESET_PC || inst0 !== mem_word(RESET_PC)) begin
            n_err++; $display("FAIL stall_first got pc=%h inst=%h exp pc=%h inst=%h", pc0, inst0, RESET_PC, mem_word(RESET_PC));
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_chk++;
            if (!s_ov || s_pc !== pc0 || s_inst !== inst0 || s_rv) begin
                n_err++; $display("FAIL stall_hold%0d got ov=%b pc=%h inst=%h rv=%b exp 1/%h/%h/0", i, s_ov, s_pc, s_inst, s_rv, pc0, inst0);
            end
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        n_chk++;
        if (s_cnt !== 32'd1 || !s_rv || s_ra !== pc0 + 32'd4) begin
            n_err++; $display("FAIL stall_release got cnt=%h rv=%b addr=%h exp 1/1/%h", s_cnt, s_rv, s_ra, pc0 + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        lat_mode = 3; out_ready = 1'b1;
        do_reset();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        cycle();
        redirect_valid = 1'b0;
        wait_req("redir_wait");
        n_chk++;
        if (s_ra !== 32'h8000_0100 || s_cnt !== 32'd0) begin
            n_err++; $display("FAIL redir_wait_req got addr=%h cnt=%h exp 80000100/0", s_ra, s_cnt);
        end
        wait_out("redir_wait");
        n_chk++;
        if (s_pc !== 32'h8000_0100) begin n_err++; $display("FAIL redir_wait_out got=%h exp=80000100", s_pc); end

        // Redirect coincident with the response: straight back to issuing
        lat_mode = 0;
        do_reset();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2008;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_chk++;
        if (!s_rv || s_ra !== 32'h0000_2008) begin
            n_err++; $display("FAIL redir_same_cycle got rv=%b addr=%h exp 1/00002008", s_rv, s_ra);
        end

        // Two redirects during one wait: only one response dropped
        lat_mode = 3;
        do_reset();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5556;
        cycle();
        redirect_valid = 1'b0;
        wait_req("redir_twice");
        n_chk++;
        if (s_ra !== 32'h0000_5554) begin n_err++; $display("FAIL redir_twice_req got=%h exp=00005554", s_ra); end
        wait_out("redir_twice");
        n_chk++;
        if (s_pc !== 32'h0000_5554) begin n_err++; $display("FAIL redir_twice_out got=%h exp=00005554", s_pc); end
    endtask

    task automatic test_redirect_out();
        lat_mode = 0; out_ready = 1'b1;
        do_reset();
        cycle(); cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
        cycle();
        n_chk++;
        if (s_ov) begin n_err++; $display("FAIL redir_out_valid got=1 exp=0"); end
        redirect_valid = 1'b0;
        cycle();
        n_chk++;
        if (!s_rv || s_ra !== 32'h1234_5678 || s_cnt !== 32'd0) begin
            n_err++; $display("FAIL redir_out_req got rv=%b addr=%h cnt=%h exp 1/12345678/0", s_rv, s_ra, s_cnt);
        end
    endtask

    task automatic test_wrap();
        lat_mode = 0; out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cycle();
        n_chk++;
        if (s_rv) begin n_err++; $display("FAIL wrap_redirect_in_req got rv=1 exp=0"); end
        redirect_valid = 1'b0;
        cycle();
        n_chk++;
        if (!s_rv || s_ra !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_req got rv=%b addr=%h exp 1/fffffffc", s_rv, s_ra);
        end
        wait_out("wrap");
        cycle();
        n_chk++;
        if (!s_rv || s_ra !== 32'h0000_0000 || s_cnt !== 32'd1) begin
            n_err++; $display("FAIL wrap_next got rv=%b addr=%h cnt=%h exp 1/00000000/1", s_rv, s_ra, s_cnt);
        end
    endtask

    task automatic test_reset_mid();
        lat_mode = 0; out_ready = 1'b1;
        do_reset();
        wait_out("reset_mid");
        lat_mode = 3;
        cycle();
        n_chk++;
        if (!s_rv || s_cnt !== 32'd1) begin n_err++; $display("FAIL reset_mid_pre got rv=%b cnt=%h exp 1/1", s_rv, s_cnt); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        n_chk++;
        if (!s_rv || s_ra !== RESET_PC || s_cnt !== 32'd0 || s_ov) begin
            n_err++; $display("FAIL reset_mid got rv=%b addr=%h cnt=%h ov=%b exp 1/%h/0/0", s_rv, s_ra, s_cnt, s_ov, RESET_PC);
        end
    endtask

    task automatic test_random();
        int hs0;
        lat_mode = -1; spur_en = 1'b1;
        do_reset();
        hs0 = n_hs;
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0; redirect_valid = 1'b0; spur_en = 1'b0;
        n_chk++;
        if (n_hs - hs0 < 100) begin n_err++; $display("FAIL random_progress got=%0d exp>=100", n_hs - hs0); end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_out();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
